// File: rtl/greedy_path_walker.sv
// ---------------------------------------------------------------------------
// greedy_path_walker
//
// Purpose:
//   Walks the 6x6 maze (states 1..36, row-major, state 1 top-left) greedily
//   over a post-blocking Q table. From each state it takes the legal action
//   with the largest unsigned Q value. Ties go to the lowest action index.
//   It records every visited state and reports how the walk ended:
//   reached, stuck, timeout or bad start.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   q_in          Q table [state 0..36][action 0..3], with actions
//                 0=N, 1=E, 2=S, 3=W; read live while busy
//   start_state   walk origin (1..36)
//   target_state  walk goal (1..36)
//   q_ready       upstream Q table is stable
//   go            start request, sampled on clk
//   busy          walk in progress
//   done          result valid; held until the next accepted go
//   status        0=reached, 1=stuck, 2=timeout, 3=bad_start
//   path          visited states in order; path[0] is the start
//   path_len      number of valid entries in path
// ---------------------------------------------------------------------------
module greedy_path_walker #(
    parameter int MAX_STEPS = 16,
    parameter int Q_W       = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [36:0][3:0][Q_W-1:0]        q_in,
    input  logic [5:0]                       start_state,
    input  logic [5:0]                       target_state,
    input  logic                             q_ready,
    input  logic                             go,
    output logic                             busy,
    output logic                             done,
    output logic [1:0]                       status,
    output logic [MAX_STEPS-1:0][5:0]        path,
    output logic [4:0]                       path_len
);

    localparam int         IDX_W       = $clog2(MAX_STEPS);
    localparam logic [4:0] LEN_MAX     = 5'(MAX_STEPS);
    localparam logic [1:0] ST_REACHED  = 2'd0;
    localparam logic [1:0] ST_STUCK    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_BADSTART = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        MOVE,
        DONE
    } state_t;

    state_t           r_state;
    logic [5:0]       r_cur;
    logic [5:0]       r_tgt;
    logic [1:0]       r_a;
    logic [Q_W-1:0]   r_best;
    logic [1:0]       r_best_a;

    logic [Q_W-1:0]   w_q;
    logic [5:0]       w_col_mod;
    logic             w_legal;
    logic [5:0]       w_nxt;
    logic             w_start_ok;
    logic             w_target_ok;
    logic             w_accept;
    logic [4:0]       w_len_next;

    // Column test uses cur mod 6: 0 means column 6, 1 means column 1.
    assign w_q        = q_in[r_cur][r_a];
    assign w_col_mod  = r_cur % 6'd6;
    assign w_len_next = path_len + 5'd1;

    assign w_start_ok  = (start_state  != 6'd0) && (start_state  <= 6'd36);
    assign w_target_ok = (target_state != 6'd0) && (target_state <= 6'd36);

    // go is only honoured when idle or holding a result, and only once the
    // upstream Q table is stable.
    assign w_accept = go && q_ready && ((r_state == IDLE) || (r_state == DONE));

    // Legality of the action currently being scanned; moves that would leave
    // the 6x6 grid are never eligible, whatever their Q value.
    always_comb begin
        w_legal = 1'b1;
        case (r_a)
            2'd0:    w_legal = (r_cur > 6'd6);
            2'd1:    w_legal = (w_col_mod != 6'd0);
            2'd2:    w_legal = (r_cur < 6'd31);
            default: w_legal = (w_col_mod != 6'd1);
        endcase
    end

    // Neighbour reached by taking the best action found during the scan.
    always_comb begin
        w_nxt = r_cur;
        case (r_best_a)
            2'd0:    w_nxt = r_cur - 6'd6;
            2'd1:    w_nxt = r_cur + 6'd1;
            2'd2:    w_nxt = r_cur + 6'd6;
            default: w_nxt = r_cur - 6'd1;
        endcase
    end

    // Walker FSM. All outputs are registered here. done is raised one cycle
    // after the decision to finish, inside DONE itself, which yields the
    // 2 + 5k cycle latency of a k-move walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_tgt    <= '0;
            r_a      <= '0;
            r_best   <= '0;
            r_best_a <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            status   <= ST_REACHED;
            path     <= '0;
            path_len <= '0;
        end else if (w_accept) begin
            r_state  <= LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            status   <= ST_REACHED;
            path     <= '0;
            path_len <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                end

                LOAD: begin
                    r_cur    <= start_state;
                    r_tgt    <= target_state;
                    r_a      <= '0;
                    r_best   <= '0;
                    r_best_a <= '0;
                    if (!w_start_ok || !w_target_ok) begin
                        status   <= ST_BADSTART;
                        path_len <= '0;
                        r_state  <= DONE;
                    end else begin
                        path[0]  <= start_state;
                        path_len <= 5'd1;
                        if (start_state == target_state) begin
                            status  <= ST_REACHED;
                            r_state <= DONE;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end

                // One action per cycle; strict compare keeps the lowest index
                // on ties.
                SCAN: begin
                    if (w_legal && (w_q > r_best)) begin
                        r_best   <= w_q;
                        r_best_a <= r_a;
                    end
                    if (r_a == 2'd3) begin
                        r_state <= MOVE;
                    end else begin
                        r_a <= r_a + 2'd1;
                    end
                end

                // A zero best means every legal move is blocked or unlearned.
                MOVE: begin
                    if (r_best == '0) begin
                        status  <= ST_STUCK;
                        r_state <= DONE;
                    end else begin
                        path[path_len[IDX_W-1:0]] <= w_nxt;
                        path_len <= w_len_next;
                        r_cur    <= w_nxt;
                        r_a      <= '0;
                        r_best   <= '0;
                        r_best_a <= '0;
                        if (w_nxt == r_tgt) begin
                            status  <= ST_REACHED;
                            r_state <= DONE;
                        end else if (w_len_next == LEN_MAX) begin
                            status  <= ST_TIMEOUT;
                            r_state <= DONE;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end

                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/greedy_path_walker.md
Name: greedy_path_walker

Overview:
- Downstream consumer of the blocked-state Q-table stage.
- Takes the post-blocking Q table for the 6x6 maze (states 1..36; index 0 unused) plus start/target states.
- Walks the maze greedily: at each state it takes the legal action with the largest Q value.
- Records the visited-state path and reports reached, stuck, timeout or bad-start. Results drive the path display and the episode controller.

Parameters:
- MAX_STEPS, 16, path buffer depth in entries, including the start state (>=2).
- Q_W, 32, width of one Q entry; compared as unsigned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- q_in  in  Q_W x [37][4]  Q table from the blocking stage; action 0=N, 1=E, 2=S, 3=W
- start_state  in  6  walk origin
- target_state  in  6  walk goal
- q_ready  in  1  blocking stage done; Q table stable
- go  in  1  start request, sampled on clk
- busy  out  1  walk in progress
- done  out  1  result valid
- status  out  2  0=reached, 1=stuck, 2=timeout, 3=bad_start
- path  out  6 x [MAX_STEPS]  visited states in order
- path_len  out  5  valid entries in path

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, status=0, path_len=0, all path entries=0, internal registers cleared.
- FSM states: IDLE, LOAD, SCAN, MOVE, DONE.
- go is accepted only in IDLE or DONE with q_ready=1. go is ignored while busy or while q_ready=0.
- Accepting go: state goes to LOAD, busy=1, done=0. Path contents are cleared to 0.
- LOAD (1 cycle):
  - Latch cur=start_state and tgt=target_state.
  - If start is 0 or >36, or target is 0 or >36: go to DONE with status=3 and path_len=0.
  - Otherwise path[0]=start and path_len=1.
  - If start==target: go to DONE with status=0.
  - Else go to SCAN with a=0, best=0, best_a=0.
- SCAN (exactly 4 cycles, a=0..3, one action per cycle):
  - Action a is legal unless: N from row 1 (cur<=6); S from row 6 (cur>=31); E from column 6 (cur mod 6==0); W from column 1 (cur mod 6==1).
  - If a is legal and q_in[cur][a] > best (strict unsigned compare): best=q_in[cur][a] and best_a=a.
  - Ties therefore resolve to the lowest action index. Illegal actions are never chosen, whatever their Q value.
- MOVE (1 cycle):
  - If best==0: DONE, status=1 (stuck). Zero Q marks blocked or unlearned moves.
  - Else nxt = cur-6 / cur+1 / cur+6 / cur-1 for N / E / S / W. Write path[path_len]=nxt, increment path_len, set cur=nxt.
  - Then, in priority order: if nxt==tgt, DONE with status=0; else if the new path_len==MAX_STEPS, DONE with status=2; else SCAN.
- DONE: busy=0, done=1. Outputs hold until reset or the next accepted go.
- Latency: a walk of k moves that reaches the target asserts done 2+5k clocks after the go-sampling edge.
  - Start==target asserts done after 2 clocks.
  - Stuck on the first state asserts done after 7 clocks.
- q_in is read live during SCAN. The upstream stage must keep it stable while busy=1.
- Reset asserted mid-walk aborts immediately. No partial result is retained.

Test Plan:
- Q all 0 except the E entries of states 1..5 =5 and the S entries of states 6,12,18,24,30 =5; start=1, target=36; go -> path 1,2,3,4,5,6,12,18,24,30,36; path_len=11; status=0; done exactly 52 clocks after go.
- Q all zero; start=1, target=36 -> status=1; path_len=1; path[0]=1; done at clock 7.
- Q[8][1]=7, Q[8][2]=7, all else 0; start=8, target=9 -> E chosen (tie goes to the lower index); path 8,9; status=0.
- Q[1][0]=100, Q[1][3]=100, Q[1][2]=1; start=1, target=7 -> illegal N/W ignored; path 1,7; status=0.
- Q[1][1]=1, Q[2][3]=1; start=1, target=36 -> status=2; path_len=16; path alternates 1,2,1,2,...
- Assert rst mid-SCAN -> busy/done/path_len drop to 0 without waiting for a clock edge. Then go with start=0 -> status=3, path_len=0. Then go with q_ready=0 -> ignored; busy stays 0.
